bram_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the single-port-pipelined block RAM in the wishbone BRAM slave. It accepts independent read/write requests from two requesters, for example the wishbone slave logic and a DMA/streaming engine. It grants one request at a time, drives the BRAM `en`/`we`/address/data pins through the BRAM's two-stage read pipeline, and returns read data plus a one-cycle acknowledge to the granted requester.

---
 rtl/bram_arbiter.sv | 150 +++++++++++++++
 tb/tb_bram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-port round-robin arbiter and sequencer for a single-port
// block RAM with a two-stage read pipeline. One transaction is in flight at a
// time. Read data is returned registered, together with a one-cycle ack to the
// port that owns the transaction.
module bram_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  busy,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_write_address,
  output logic [ADDR_WIDTH-1:0] bram_read_address,
  output logic [DATA_WIDTH-1:0] bram_data_in,
  input  logic [DATA_WIDTH-1:0] bram_data_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    RD2  = 3'd4,
    ACK  = 3'd5
  } state_t;

  state_t                state;
  logic                  last_grant;  // port granted most recently
  logic                  grant_q;     // port owning the current transaction
  logic                  we_lat;
  logic [ADDR_WIDTH-1:0] addr_lat;
  logic [DATA_WIDTH-1:0] din_lat;

  // Candidate grant and the request fields of that port, evaluated in IDLE.
  logic                  grant;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;

  // The BRAM pins come only from the latched request, never from live inputs.
  assign bram_write_address = addr_lat;
  assign bram_read_address  = addr_lat;
  assign bram_data_in       = din_lat;

  // Round-robin choice: a lone requester always wins, contention goes to the
  // port that was not served last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = 1'b1;
    end
    sel_we   = grant ? we1   : we0;
    sel_addr = grant ? addr1 : addr0;
    sel_din  = grant ? din1  : din0;
  end

  // Transaction sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      we_lat     <= 1'b0;
      addr_lat   <= '0;
      din_lat    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      dout0      <= '0;
      dout1      <= '0;
      busy       <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant_q    <= grant;
            last_grant <= grant;
            we_lat     <= sel_we;
            addr_lat   <= sel_addr;
            din_lat    <= sel_din;
            busy       <= 1'b1;
            bram_en    <= 1'b1;
            bram_we    <= sel_we;
            state      <= sel_we ? WR : RD0;
          end
        end
        WR: begin
          bram_en <= 1'b0;
          bram_we <= 1'b0;
          ack0    <= ~grant_q;
          ack1    <= grant_q;
          state   <= ACK;
        end
        RD0: begin
          // Address is captured by the BRAM at this edge; keep it enabled.
          state <= RD1;
        end
        RD1: begin
          // Data is produced at this edge; disable so it holds through RD2.
          bram_en <= 1'b0;
          state   <= RD2;
        end
        RD2: begin
          if (grant_q) begin
            dout1 <= bram_data_out;
          end else begin
            dout0 <= bram_data_out;
          end
          ack0  <= ~grant_q;
          ack1  <= grant_q;
          state <= ACK;
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          bram_en <= 1'b0;
          bram_we <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural two-stage BRAM model and
// a scoreboard of expected acknowledges (port, read data) in grant order.
module tb_bram_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, din1;
  logic          ack0, ack1, busy, bram_en, bram_we;
  logic [DW-1:0] dout0, dout1;
  logic [AW-1:0] bram_write_address, bram_read_address;
  logic [DW-1:0] bram_data_in, bram_data_out;

  int n_assert = 0;
  int n_fail   = 0;

  bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
    .ack0(ack0), .dout0(dout0), .ack1(ack1), .dout1(dout1),
    .busy(busy), .bram_en(bram_en), .bram_we(bram_we),
    .bram_write_address(bram_write_address),
    .bram_read_address(bram_read_address),
    .bram_data_in(bram_data_in), .bram_data_out(bram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: registered read address, data two enabled edges later.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_q;
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ram_addr_q    = '0;
    bram_data_out = '0;
  end
  always @(posedge clk) begin
    if (bram_en) begin
      ram_addr_q    <= bram_read_address;
      bram_data_out <= mem[ram_addr_q];
      if (bram_we) mem[bram_write_address] <= bram_data_in;
    end
  end

  // Reference contents used to derive expected read data.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;

  typedef struct {
    bit            port;
    bit            is_wr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] exp_dout [2];
  initial begin
    exp_dout[0] = '0;
    exp_dout[1] = '0;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Record the expected outcome of a transaction in grant order.
  task automatic push_expect(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.port  = p;
    e.is_wr = w;
    if (w) begin
      ref_mem[a] = d;
      e.data     = '0;
    end else begin
      e.data = ref_mem[a];
    end
    sb.push_back(e);
  endtask

  task automatic set_port(input bit p, input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin
      req1 = r; we1 = w; addr1 = a; din1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; din0 = d;
    end
  endtask

  // Wait (bounded) for the ack of port p; cyc counts negedges before the ack.
  task automatic wait_ack(input bit p, output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      if (p ? ack1 : ack0) seen = 1'b1;
      else cyc++;
    end
    chk("ack_timeout", {31'd0, seen}, 32'd1);
  endtask

  // Single-port transaction with latency and BRAM pin checks per cycle.
  task automatic txn(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int  n    = 0;
    bit  seen = 1'b0;
    push_expect(p, w, a, d);
    @(posedge clk); #1;
    set_port(p, 1'b1, w, a, d);
    while (!seen && n < 20) begin
      @(negedge clk);
      if (w && n == 1) begin
        chk("wr_en", {31'd0, bram_en}, 32'd1);
        chk("wr_we", {31'd0, bram_we}, 32'd1);
        chk("wr_addr", {19'd0, bram_write_address}, {19'd0, a});
        chk("wr_data", bram_data_in, d);
      end else if (!w && (n == 1 || n == 2)) begin
        chk("rd_en", {31'd0, bram_en}, 32'd1);
        chk("rd_we", {31'd0, bram_we}, 32'd0);
        chk("rd_addr", {19'd0, bram_read_address}, {19'd0, a});
      end else if (!w && n == 3) begin
        chk("rd2_en", {31'd0, bram_en}, 32'd0);
      end
      if (p ? ack1 : ack0) begin
        seen = 1'b1;
        chk("ack_cycle_en", {31'd0, bram_en}, 32'd0);
      end else begin
        n++;
      end
    end
    chk(w ? "wr_latency" : "rd_latency", 32'(n), w ? 32'd2 : 32'd4);
    @(posedge clk); #1;
    set_port(p, 1'b0, w, a, d);
  endtask

  // Monitor: bus rules every cycle, scoreboard comparison on every ack.
  always @(negedge clk) begin
    if (!rst) begin
      if (bram_we) chk("we_without_en", {31'd0, bram_en}, 32'd1);
      if (ack0) chk("ack0_without_req", {31'd0, req0}, 32'd1);
      if (ack1) chk("ack1_without_req", {31'd0, req1}, 32'd1);
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", {30'd0, ack1, ack0}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_port", {30'd0, ack1, ack0}, mon_e.port ? 32'd2 : 32'd1);
          if (!mon_e.is_wr) exp_dout[mon_e.port] = mon_e.data;
          chk(mon_e.port ? "dout1_value" : "dout0_value",
              mon_e.port ? dout1 : dout0, exp_dout[mon_e.port]);
          chk(mon_e.port ? "dout0_isolated" : "dout1_isolated",
              mon_e.port ? dout0 : dout1, exp_dout[~mon_e.port]);
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_dout[0] = '0;
    exp_dout[1] = '0;
  endtask

  initial begin
    int c;
    int acks;
    int cyc;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; din0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;

    // Reset: two cycles, then every output must be zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_en", {31'd0, bram_en}, 32'd0);
    chk("rst_we", {31'd0, bram_we}, 32'd0);
    chk("rst_dout0", dout0, 32'd0);
    chk("rst_dout1", dout1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read of preloaded zero, then write/read-back on port 0.
    txn(1'b0, 1'b0, 13'h000, 32'h0);
    txn(1'b0, 1'b1, 13'h005, 32'hDEADBEEF);
    txn(1'b0, 1'b0, 13'h005, 32'h0);
    txn(1'b1, 1'b1, 13'h010, 32'hA5A5_0F0F);
    txn(1'b1, 1'b0, 13'h010, 32'h0);

    // Contention: both reads rise together; port 0 wins after port 1 served.
    push_expect(1'b0, 1'b0, 13'h005, 32'h0);
    push_expect(1'b1, 1'b0, 13'h000, 32'h0);
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 13'h005, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 13'h000, 32'h0);
    wait_ack(1'b0, c);
    chk("cont_lat0", 32'(c), 32'd4);
    @(posedge clk); #1;
    req0 = 1'b0;
    wait_ack(1'b1, c);
    chk("cont_lat1", 32'(c), 32'd4);
    @(posedge clk); #1;
    req1 = 1'b0;

    // Both held permanently: acks must alternate 0,1,0,1.
    push_expect(1'b0, 1'b0, 13'h005, 32'h0);
    push_expect(1'b1, 1'b0, 13'h010, 32'h0);
    push_expect(1'b0, 1'b0, 13'h005, 32'h0);
    push_expect(1'b1, 1'b0, 13'h010, 32'h0);
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 13'h005, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 13'h010, 32'h0);
    acks = 0;
    cyc  = 0;
    while (acks < 4 && cyc < 100) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
      cyc++;
    end
    chk("hold_ack_count", 32'(acks), 32'd4);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;

    // Isolation: after reset port 0 reads 0x1FFF ahead of port 1's write.
    do_reset(1);
    push_expect(1'b0, 1'b0, 13'h1FFF, 32'h0);
    push_expect(1'b1, 1'b1, 13'h1FFF, 32'h12345678);
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 13'h1FFF, 32'h0);
    set_port(1'b1, 1'b1, 1'b1, 13'h1FFF, 32'h12345678);
    wait_ack(1'b0, c);
    chk("iso_lat0", 32'(c), 32'd4);
    @(posedge clk); #1;
    req0 = 1'b0;
    wait_ack(1'b1, c);
    chk("iso_lat1", 32'(c), 32'd2);
    @(posedge clk); #1;
    req1 = 1'b0;
    txn(1'b0, 1'b0, 13'h1FFF, 32'h0);

    // Reset during RD1: no ack, dout0 cleared, IDLE next cycle.
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 13'h005, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst  = 1'b1;
    req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ack0", {31'd0, ack0}, 32'd0);
    chk("midrst_en", {31'd0, bram_en}, 32'd0);
    chk("midrst_dout0", dout0, 32'd0);
    repeat (4) @(negedge clk);
    chk("midrst_no_late_ack", {30'd0, ack1, ack0}, 32'd0);
    txn(1'b0, 1'b0, 13'h005, 32'h0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
